// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: two debounced buttons drive a colour index that steps
// manually or on a periodic auto timer; each index bit lights one LED
// channel through a shared fixed-duty PWM.
module rgb_pwm_sequencer #(
  parameter int CHANNELS     = 3,
  parameter int BOUNCE_TICKS = 250,
  parameter int AUTO_TICKS   = 12_000_000,
  parameter int PWM_BITS     = 8,
  parameter int DUTY         = 2**PWM_BITS/4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_button,
  input  logic                mode_button,
  output logic [CHANNELS-1:0] rgb,
  output logic [CHANNELS-1:0] step_index,
  output logic                auto_mode
);

  localparam int DB_W = $clog2(BOUNCE_TICKS + 1);
  localparam int TM_W = $clog2(AUTO_TICKS + 1);
  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(BOUNCE_TICKS - 1);
  localparam logic [TM_W-1:0]     TM_LAST  = TM_W'(AUTO_TICKS - 1);
  // One extra bit so DUTY == 2**PWM_BITS (always on) is representable.
  localparam logic [PWM_BITS:0]   DUTY_CMP = (PWM_BITS + 1)'(DUTY);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  // Button 0 is step, button 1 is mode.
  logic [1:0] w_raw;
  logic [1:0] w_press;
  logic       w_step_press;
  logic       w_mode_press;

  assign w_raw        = {mode_button, step_button};
  assign w_step_press = w_press[0];
  assign w_mode_press = w_press[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_level;
      logic            r_level_d;
      logic [DB_W-1:0] r_cnt;

      // Synchronise the raw button, then accept a new level only after it has
      // disagreed with the current level for BOUNCE_TICKS cycles in a row.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync1   <= 1'b0;
          r_sync2   <= 1'b0;
          r_level   <= 1'b0;
          r_level_d <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_sync1   <= w_raw[gi];
          r_sync2   <= r_sync1;
          r_level_d <= r_level;
          if (r_sync2 != r_level) begin
            if (r_cnt == DB_LAST) begin
              r_level <= r_sync2;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      // Rising edge of the debounced level is the one-cycle press pulse.
      assign w_press[gi] = r_level & ~r_level_d;
    end
  endgenerate

  state_t              r_state;
  logic [TM_W-1:0]     r_timer;
  logic [CHANNELS-1:0] r_step_index;
  logic                r_auto_mode;

  // Mode FSM with auto timer; a step press always wins over a coincident
  // timer expiry so the index moves by exactly one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= MANUAL;
      r_auto_mode  <= 1'b0;
      r_timer      <= '0;
      r_step_index <= '0;
    end else begin
      case (r_state)
        MANUAL: begin
          if (w_step_press) r_step_index <= r_step_index + 1'b1;
          if (w_mode_press) begin
            r_state     <= AUTO;
            r_auto_mode <= 1'b1;
            r_timer     <= '0;
          end
        end
        AUTO: begin
          if (w_mode_press) begin
            r_state     <= MANUAL;
            r_auto_mode <= 1'b0;
            r_timer     <= '0;
            if (w_step_press) r_step_index <= r_step_index + 1'b1;
          end else if (w_step_press) begin
            r_step_index <= r_step_index + 1'b1;
            r_timer      <= '0;
          end else if (r_timer == TM_LAST) begin
            r_step_index <= r_step_index + 1'b1;
            r_timer      <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state     <= MANUAL;
          r_auto_mode <= 1'b0;
          r_timer     <= '0;
        end
      endcase
    end
  end

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [CHANNELS-1:0] r_rgb;
  logic                w_pwm_on;

  assign w_pwm_on = ({1'b0, r_pwm_cnt} < DUTY_CMP);

  // Free-running PWM counter and registered, gated LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_rgb     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_rgb     <= r_step_index & {CHANNELS{w_pwm_on}};
    end
  end

  assign rgb        = r_rgb;
  assign step_index = r_step_index;
  assign auto_mode  = r_auto_mode;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer: directed button scenarios with literal
// expectations plus a cycle-level behavioural model compared every cycle.
module tb_rgb_pwm_sequencer;

  localparam int CH  = 3;
  localparam int BT  = 4;
  localparam int AT  = 10;
  localparam int PB  = 3;
  localparam int DU  = 4;
  localparam int NIDX = 1 << CH;
  localparam int NPWM = 1 << PB;
  localparam int DB_MASK = (1 << BT) - 1;

  logic          clk;
  logic          rst;
  logic          step_button;
  logic          mode_button;
  logic [CH-1:0] rgb;
  logic [CH-1:0] step_index;
  logic          auto_mode;

  int checks   = 0;
  int failures = 0;

  rgb_pwm_sequencer #(
    .CHANNELS(CH), .BOUNCE_TICKS(BT), .AUTO_TICKS(AT), .PWM_BITS(PB), .DUTY(DU)
  ) dut (
    .clk(clk), .rst(rst), .step_button(step_button), .mode_button(mode_button),
    .rgb(rgb), .step_index(step_index), .auto_mode(auto_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each button: raw value reaches the debouncer two edges later; the
  // debounced level flips once the last BT observed values all disagree
  // with it, and a flip to 1 is a press acted on at the following edge.
  bit       m_valid = 0;
  int       m_idx, m_auto, m_timer, m_rgb, m_pwm;
  bit [7:0] m_hist  [2];
  bit       m_lvl   [2];
  bit       m_p1    [2];
  bit       m_p2    [2];
  bit       m_press [2];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1;
        m_idx = 0; m_auto = 0; m_timer = 0; m_rgb = 0; m_pwm = 0;
        for (int b = 0; b < 2; b++) begin
          m_hist[b] = 0; m_lvl[b] = 0; m_p1[b] = 0; m_p2[b] = 0; m_press[b] = 0;
        end
      end else begin
        int inc;
        bit raw [2];
        bit seen;
        inc = 0;
        if (m_press[0]) inc = 1;
        if (m_press[1]) begin
          m_auto  = 1 - m_auto;
          m_timer = 0;
        end else if (m_auto == 1) begin
          if (m_press[0]) m_timer = 0;
          else if (m_timer == AT - 1) begin m_timer = 0; inc = 1; end
          else m_timer = m_timer + 1;
        end
        m_rgb = (m_pwm < DU) ? m_idx : 0;
        m_pwm = (m_pwm + 1) % NPWM;
        m_idx = (m_idx + inc) % NIDX;
        raw[0] = step_button;
        raw[1] = mode_button;
        for (int b = 0; b < 2; b++) begin
          seen     = m_p2[b];
          m_p2[b]  = m_p1[b];
          m_p1[b]  = raw[b];
          m_hist[b] = {m_hist[b][6:0], seen};
          m_press[b] = 0;
          if ((int'(m_hist[b]) & DB_MASK) == (m_lvl[b] ? 0 : DB_MASK)) begin
            m_lvl[b]   = ~m_lvl[b];
            m_press[b] = m_lvl[b];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model_step_index", int'(step_index), m_idx);
        chk("model_auto_mode", int'(auto_mode), m_auto);
        chk("model_rgb", int'(rgb), m_rgb);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; step_button = 0; mode_button = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic press_step();
    step_button = 1; tick(8);
    step_button = 0; tick(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int nchg;
    int chg [3];
    int prev;
    int c0, c1, c2;

    rst = 0; step_button = 0; mode_button = 0;

    // Reset state
    do_reset();
    chk("reset_step_index", int'(step_index), 0);
    chk("reset_auto_mode", int'(auto_mode), 0);
    chk("reset_rgb", int'(rgb), 0);
    $display("txn reset: step_index=%0d auto_mode=%0d rgb=%0d", step_index, auto_mode, rgb);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold high
    for (int i = 0; i < 10; i++) begin
      step_button = (i % 2 == 0);
      tick(2);
    end
    chk("bounce_no_step", int'(step_index), 0);
    step_button = 1; tick(8);
    chk("bounce_one_step", int'(step_index), 1);
    tick(8);
    chk("bounce_held_no_repeat", int'(step_index), 1);
    step_button = 0; tick(10);
    chk("bounce_release_no_step", int'(step_index), 1);
    $display("txn bounce: step_index=%0d", step_index);

    // Manual wrap: 8 presses from reset
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      press_step();
      chk("manual_step_index", int'(step_index), i % NIDX);
      chk("manual_auto_mode", int'(auto_mode), 0);
      $display("txn manual press %0d: step_index=%0d auto_mode=%0d", i, step_index, auto_mode);
    end

    // Auto: mode press, then 30 idle cycles
    do_reset();
    mode_button = 1;
    t = 0;
    while (auto_mode !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    chk("auto_enter", int'(auto_mode), 1);
    chk("mode_press_latency", t, 7);
    mode_button = 0;
    nchg = 0;
    prev = step_index;
    for (int n = 1; n <= 30; n++) begin
      tick(1);
      if (int'(step_index) != prev) begin
        if (nchg < 3) chg[nchg] = n;
        nchg++;
        prev = step_index;
      end
    end
    chk("auto_advance_count", nchg, 3);
    chk("auto_advance_1", chg[0], 10);
    chk("auto_advance_2", chg[1], 20);
    chk("auto_advance_3", chg[2], 30);
    chk("auto_index_after_30", int'(step_index), 3);
    $display("txn auto: advances=%0d step_index=%0d auto_mode=%0d", nchg, step_index, auto_mode);

    // Collision: step press pulse lands on the expiry edge (cycle 40)
    for (int n = 31; n <= 50; n++) begin
      tick(1);
      if (n == 33) step_button = 1;
      if (n == 41) step_button = 0;
      if (n == 39) chk("collision_before", int'(step_index), 3);
      if (n == 40) chk("collision_single_inc", int'(step_index), 4);
      if (n == 49) chk("collision_hold", int'(step_index), 4);
      if (n == 50) chk("collision_next_advance", int'(step_index), 5);
    end
    chk("collision_still_auto", int'(auto_mode), 1);
    $display("txn collision: step_index=%0d auto_mode=%0d", step_index, auto_mode);

    // PWM at step_index = 5
    do_reset();
    for (int i = 0; i < 5; i++) press_step();
    chk("pwm_index", int'(step_index), 5);
    c0 = 0; c1 = 0; c2 = 0;
    for (int n = 0; n < 16; n++) begin
      tick(1);
      c0 += int'(rgb[0]);
      c1 += int'(rgb[1]);
      c2 += int'(rgb[2]);
    end
    chk("pwm_rgb0_high_cycles", c0, 8);
    chk("pwm_rgb1_high_cycles", c1, 0);
    chk("pwm_rgb2_high_cycles", c2, 8);
    $display("txn pwm: rgb0=%0d rgb1=%0d rgb2=%0d of 16", c0, c1, c2);

    // Reset mid-operation in AUTO at step_index = 6
    press_step();
    mode_button = 1; tick(8);
    chk("midrst_pre_auto", int'(auto_mode), 1);
    chk("midrst_pre_index", int'(step_index), 6);
    rst = 1; tick(1);
    chk("midrst_index", int'(step_index), 0);
    chk("midrst_auto", int'(auto_mode), 0);
    chk("midrst_rgb", int'(rgb), 0);
    $display("txn midreset: step_index=%0d auto_mode=%0d rgb=%0d", step_index, auto_mode, rgb);

    // Mode button held through reset release gives one fresh press
    rst = 0; tick(5);
    chk("held_thru_reset_early", int'(auto_mode), 0);
    tick(5);
    chk("held_thru_reset_press", int'(auto_mode), 1);
    mode_button = 0; tick(10);
    chk("held_thru_reset_single", int'(auto_mode), 1);
    $display("txn held-through-reset: auto_mode=%0d", auto_mode);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
